// File: rtl/rv32im_trap_seq.sv
// Trap-entry / mret CSR sequencer for rv32im. Owns the single CSR regfile port,
// walks the multi-cycle CSR sequences and grants pipeline Zicsr accesses when idle.
//
// state      | meaning
// IDLE       | no sequence; pipeline may be granted the CSR port
// T_RMST     | trap: read mstatus into mst_q
// T_MEPC     | trap: write mepc (word aligned pc)
// T_MCAUSE   | trap: write mcause
// T_MTVAL    | trap: write mtval
// T_WMST     | trap: write mstatus (MPIE<=MIE, MIE<=0, MPP<=priv)
// T_RVEC     | trap: read mtvec, compute handler target
// M_RMST     | mret: read mstatus into mst_q
// M_WMST     | mret: write mstatus (MIE<=MPIE, MPIE<=1, MPP<=0), keep old MPP
// M_RMEPC    | mret: read mepc as return target
// REDIRECT   | one-cycle redirect strobe, privilege switch at end of cycle
module rv32im_trap_seq #(
  parameter int         XLEN       = 32,
  parameter int         CSR_AW     = 12,
  parameter logic [1:0] RESET_PRIV = 2'b11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              trap_req_i,
  input  logic [XLEN-1:0]   trap_cause_i,
  input  logic [XLEN-1:0]   trap_pc_i,
  input  logic [XLEN-1:0]   trap_tval_i,
  input  logic              mret_req_i,
  input  logic              pipe_csr_req_i,
  input  logic [CSR_AW-1:0] pipe_csr_addr_i,
  input  logic [XLEN-1:0]   pipe_csr_wdata_i,
  input  logic              pipe_csr_we_i,
  output logic              pipe_csr_gnt_o,
  output logic [XLEN-1:0]   pipe_csr_rdata_o,
  output logic [CSR_AW-1:0] csr_addr_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic              csr_write_en_o,
  output logic              csr_read_en_o,
  input  logic [XLEN-1:0]   csr_rdata_i,
  output logic [1:0]        priv_mode_o,
  output logic              redirect_valid_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              busy_o
);

  localparam logic [CSR_AW-1:0] ADDR_MSTATUS = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] ADDR_MTVEC   = CSR_AW'(12'h305);
  localparam logic [CSR_AW-1:0] ADDR_MEPC    = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] ADDR_MCAUSE  = CSR_AW'(12'h342);
  localparam logic [CSR_AW-1:0] ADDR_MTVAL   = CSR_AW'(12'h343);

  typedef enum logic [3:0] {
    S_IDLE, S_T_RMST, S_T_MEPC, S_T_MCAUSE, S_T_MTVAL, S_T_WMST, S_T_RVEC,
    S_M_RMST, S_M_WMST, S_M_RMEPC, S_REDIRECT
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   tval_q, tval_d;
  logic [XLEN-1:0]   mst_q, mst_d;
  logic [XLEN-1:0]   target_q, target_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic [1:0]        priv_q, priv_d;
  logic [1:0]        priv_nxt_q, priv_nxt_d;

  logic [XLEN-1:0]   mst_trap, mst_mret, vec_base;

  always_comb begin
    mst_trap        = mst_q;
    mst_trap[7]     = mst_q[3];
    mst_trap[3]     = 1'b0;
    mst_trap[12:11] = priv_q;

    mst_mret        = mst_q;
    mst_mret[3]     = mst_q[7];
    mst_mret[7]     = 1'b1;
    mst_mret[12:11] = 2'b00;

    vec_base = {csr_rdata_i[XLEN-1:2], 2'b00};

    state_d       = state_q;
    cause_d       = cause_q;
    pc_d          = pc_q;
    tval_d        = tval_q;
    mst_d         = mst_q;
    target_d      = target_q;
    redirect_pc_d = redirect_pc_q;
    priv_d        = priv_q;
    priv_nxt_d    = priv_nxt_q;

    csr_addr_o       = '0;
    csr_wdata_o      = '0;
    csr_write_en_o   = 1'b0;
    csr_read_en_o    = 1'b0;
    pipe_csr_gnt_o   = 1'b0;
    pipe_csr_rdata_o = '0;

    case (state_q)
      S_IDLE: begin
        if (trap_req_i) begin
          state_d = S_T_RMST;
          cause_d = trap_cause_i;
          pc_d    = {trap_pc_i[XLEN-1:2], 2'b00};
          tval_d  = trap_tval_i;
        end else if (mret_req_i) begin
          state_d = S_M_RMST;
        end else if (pipe_csr_req_i) begin
          pipe_csr_gnt_o   = 1'b1;
          csr_addr_o       = pipe_csr_addr_i;
          csr_wdata_o      = pipe_csr_wdata_i;
          csr_write_en_o   = pipe_csr_we_i;
          csr_read_en_o    = 1'b1;
          pipe_csr_rdata_o = csr_rdata_i;
        end
      end
      S_T_RMST: begin
        csr_addr_o    = ADDR_MSTATUS;
        csr_read_en_o = 1'b1;
        mst_d         = csr_rdata_i;
        state_d       = S_T_MEPC;
      end
      S_T_MEPC: begin
        csr_addr_o     = ADDR_MEPC;
        csr_wdata_o    = pc_q;
        csr_write_en_o = 1'b1;
        state_d        = S_T_MCAUSE;
      end
      S_T_MCAUSE: begin
        csr_addr_o     = ADDR_MCAUSE;
        csr_wdata_o    = cause_q;
        csr_write_en_o = 1'b1;
        state_d        = S_T_MTVAL;
      end
      S_T_MTVAL: begin
        csr_addr_o     = ADDR_MTVAL;
        csr_wdata_o    = tval_q;
        csr_write_en_o = 1'b1;
        state_d        = S_T_WMST;
      end
      S_T_WMST: begin
        csr_addr_o     = ADDR_MSTATUS;
        csr_wdata_o    = mst_trap;
        csr_write_en_o = 1'b1;
        state_d        = S_T_RVEC;
      end
      S_T_RVEC: begin
        csr_addr_o    = ADDR_MTVEC;
        csr_read_en_o = 1'b1;
        // Vectored mode only offsets interrupts; the add wraps at XLEN bits.
        if (csr_rdata_i[1:0] == 2'b01 && cause_q[XLEN-1])
          target_d = vec_base + {cause_q[XLEN-3:0], 2'b00};
        else
          target_d = vec_base;
        priv_nxt_d = 2'b11;
        state_d    = S_REDIRECT;
      end
      S_M_RMST: begin
        csr_addr_o    = ADDR_MSTATUS;
        csr_read_en_o = 1'b1;
        mst_d         = csr_rdata_i;
        state_d       = S_M_WMST;
      end
      S_M_WMST: begin
        csr_addr_o     = ADDR_MSTATUS;
        csr_wdata_o    = mst_mret;
        csr_write_en_o = 1'b1;
        priv_nxt_d     = mst_q[12:11];
        state_d        = S_M_RMEPC;
      end
      S_M_RMEPC: begin
        csr_addr_o    = ADDR_MEPC;
        csr_read_en_o = 1'b1;
        target_d      = {csr_rdata_i[XLEN-1:2], 2'b00};
        state_d       = S_REDIRECT;
      end
      S_REDIRECT: begin
        priv_d        = priv_nxt_q;
        redirect_pc_d = target_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A reset in the same cycle must not let a pending write commit.
    if (rst_i) begin
      csr_write_en_o   = 1'b0;
      csr_read_en_o    = 1'b0;
      pipe_csr_gnt_o   = 1'b0;
      pipe_csr_rdata_o = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      cause_q       <= '0;
      pc_q          <= '0;
      tval_q        <= '0;
      mst_q         <= '0;
      target_q      <= '0;
      redirect_pc_q <= '0;
      priv_q        <= RESET_PRIV;
      priv_nxt_q    <= '0;
    end else begin
      state_q       <= state_d;
      cause_q       <= cause_d;
      pc_q          <= pc_d;
      tval_q        <= tval_d;
      mst_q         <= mst_d;
      target_q      <= target_d;
      redirect_pc_q <= redirect_pc_d;
      priv_q        <= priv_d;
      priv_nxt_q    <= priv_nxt_d;
    end
  end

  assign busy_o           = (state_q != S_IDLE);
  assign redirect_valid_o = (state_q == S_REDIRECT) & ~rst_i;
  assign redirect_pc_o    = (state_q == S_REDIRECT) ? target_q : redirect_pc_q;
  assign priv_mode_o      = priv_q;

endmodule

// File: tb/tb_rv32im_trap_seq.sv
// Bench for rv32im_trap_seq: a behavioural CSR regfile plus directed trap,
// mret, pipeline-access, collision and reset sequences.
module tb_rv32im_trap_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        trap_req_i;
  logic [31:0] trap_cause_i, trap_pc_i, trap_tval_i;
  logic        mret_req_i;
  logic        pipe_csr_req_i;
  logic [11:0] pipe_csr_addr_i;
  logic [31:0] pipe_csr_wdata_i;
  logic        pipe_csr_we_i;
  logic        pipe_csr_gnt_o;
  logic [31:0] pipe_csr_rdata_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_wdata_o;
  logic        csr_write_en_o, csr_read_en_o;
  logic [31:0] csr_rdata_i;
  logic [1:0]  priv_mode_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        busy_o;

  rv32im_trap_seq #(.XLEN(32), .CSR_AW(12), .RESET_PRIV(2'b11)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .trap_req_i(trap_req_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
    .trap_tval_i(trap_tval_i), .mret_req_i(mret_req_i),
    .pipe_csr_req_i(pipe_csr_req_i), .pipe_csr_addr_i(pipe_csr_addr_i),
    .pipe_csr_wdata_i(pipe_csr_wdata_i), .pipe_csr_we_i(pipe_csr_we_i),
    .pipe_csr_gnt_o(pipe_csr_gnt_o), .pipe_csr_rdata_o(pipe_csr_rdata_o),
    .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
    .csr_write_en_o(csr_write_en_o), .csr_read_en_o(csr_read_en_o),
    .csr_rdata_i(csr_rdata_i), .priv_mode_o(priv_mode_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural CSR regfile: combinational read, write at rising edge.
  logic [31:0] csr_mem [0:4095];
  int          wr_cnt  [0:4095];
  int          redir_cnt = 0;
  assign csr_rdata_i = csr_mem[csr_addr_o];

  always @(posedge clk_i) begin
    if (csr_write_en_o) begin
      csr_mem[csr_addr_o] <= csr_wdata_o;
      wr_cnt[csr_addr_o]  <= wr_cnt[csr_addr_o] + 1;
    end
    if (redirect_valid_o) redir_cnt <= redir_cnt + 1;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pipe_wr(input logic [11:0] a, input logic [31:0] d);
    logic g;
    g = 1'b0;
    pipe_csr_req_i = 1'b1; pipe_csr_addr_i = a; pipe_csr_wdata_i = d; pipe_csr_we_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      g = pipe_csr_gnt_o;
      step();
      if (g) break;
    end
    pipe_csr_req_i = 1'b0; pipe_csr_we_i = 1'b0;
    chk("preload_gnt", {31'b0, g}, 32'd1);
  endtask

  // Called right after the accepting edge; returns cycle index of the strobe.
  task automatic wait_redirect(output int k_seen, output logic [31:0] pc_seen,
                               output logic busy_all);
    k_seen = 0; pc_seen = '0; busy_all = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_i);
      busy_all = busy_all & busy_o;
      if (redirect_valid_o) begin
        k_seen  = k;
        pc_seen = redirect_pc_o;
      end
      step();
      if (k_seen != 0) break;
    end
  endtask

  typedef struct {
    logic [31:0] mtvec, mst, cause, pc, tval;
    logic [31:0] exp_tgt, exp_mst, exp_mepc;
  } trap_vec_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] exp_rdata;
  } pipe_vec_t;

  trap_vec_t tv [5];
  pipe_vec_t pv [5];

  int          k_seen, gnt_k;
  logic [31:0] pc_seen;
  logic        busy_all;
  int          s_mepc, s_mcause, s_mtval, s_mst, s_redir;

  task automatic snap();
    s_mepc = wr_cnt[12'h341]; s_mcause = wr_cnt[12'h342];
    s_mtval = wr_cnt[12'h343]; s_mst = wr_cnt[12'h300]; s_redir = redir_cnt;
  endtask

  task automatic do_mret(input string tag, input logic [31:0] mst, input logic [31:0] mepc,
                         input logic [31:0] exp_mst, input logic [31:0] exp_pc,
                         input logic [1:0] exp_priv);
    pipe_wr(12'h300, mst);
    pipe_wr(12'h341, mepc);
    mret_req_i = 1'b1;
    step();
    mret_req_i = 1'b0;
    wait_redirect(k_seen, pc_seen, busy_all);
    chk({tag, "_strobe_cycle"}, 32'(k_seen), 32'd4);
    chk({tag, "_redirect_pc"}, pc_seen, exp_pc);
    chk({tag, "_mstatus"}, csr_mem[12'h300], exp_mst);
    @(negedge clk_i);
    chk({tag, "_priv"}, {30'b0, priv_mode_o}, {30'b0, exp_priv});
    step();
  endtask

  initial begin
    tv[0] = '{32'h0000_0100, 32'h0000_0008, 32'h0000_0002, 32'h0000_0080, 32'h0000_DEAD,
              32'h0000_0100, 32'h0000_1880, 32'h0000_0080};
    tv[1] = '{32'h0000_0201, 32'h0000_0008, 32'h8000_0007, 32'h0000_1002, 32'h0000_0000,
              32'h0000_021C, 32'h0000_1880, 32'h0000_1000};
    tv[2] = '{32'h0000_0201, 32'h0000_0000, 32'h0000_0002, 32'h0000_0200, 32'h0000_0005,
              32'h0000_0200, 32'h0000_1800, 32'h0000_0200};
    tv[3] = '{32'hFFFF_FFF1, 32'hFFFF_0008, 32'h8000_0005, 32'h0000_0003, 32'h0000_0007,
              32'h0000_0004, 32'hFFFF_1880, 32'h0000_0000};
    tv[4] = '{32'h0000_0102, 32'h0000_0000, 32'h8000_0003, 32'h0000_0040, 32'h0000_0001,
              32'h0000_0100, 32'h0000_1800, 32'h0000_0040};

    // Expected read data assumes the regfile state left by tv[4].
    pv[0] = '{12'h300, 32'hF000_0000, 1'b1, 32'h0000_1800};
    pv[1] = '{12'h300, 32'h0000_0000, 1'b0, 32'hF000_0000};
    pv[2] = '{12'h342, 32'h0000_000B, 1'b1, 32'h8000_0003};
    pv[3] = '{12'h342, 32'h0000_0000, 1'b0, 32'h0000_000B};
    pv[4] = '{12'h343, 32'h0000_0000, 1'b0, 32'h0000_0001};

    rst_i = 1'b1; trap_req_i = 1'b0; mret_req_i = 1'b0;
    trap_cause_i = '0; trap_pc_i = '0; trap_tval_i = '0;
    pipe_csr_req_i = 1'b0; pipe_csr_addr_i = '0; pipe_csr_wdata_i = '0; pipe_csr_we_i = 1'b0;
    repeat (3) step();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_redirect_valid", {31'b0, redirect_valid_o}, 32'd0);
    chk("rst_redirect_pc", redirect_pc_o, 32'd0);
    chk("rst_enables", {30'b0, csr_write_en_o, csr_read_en_o}, 32'd0);
    chk("rst_gnt", {31'b0, pipe_csr_gnt_o}, 32'd0);
    chk("rst_priv", {30'b0, priv_mode_o}, 32'd3);
    step();

    for (int i = 0; i < 5; i++) begin
      pipe_wr(12'h305, tv[i].mtvec);
      pipe_wr(12'h300, tv[i].mst);
      snap();
      trap_req_i = 1'b1; trap_cause_i = tv[i].cause; trap_pc_i = tv[i].pc; trap_tval_i = tv[i].tval;
      step();
      trap_req_i = 1'b0;
      wait_redirect(k_seen, pc_seen, busy_all);
      chk($sformatf("trap%0d_strobe_cycle", i), 32'(k_seen), 32'd7);
      chk($sformatf("trap%0d_redirect_pc", i), pc_seen, tv[i].exp_tgt);
      chk($sformatf("trap%0d_busy", i), {31'b0, busy_all}, 32'd1);
      chk($sformatf("trap%0d_mepc", i), csr_mem[12'h341], tv[i].exp_mepc);
      chk($sformatf("trap%0d_mcause", i), csr_mem[12'h342], tv[i].cause);
      chk($sformatf("trap%0d_mtval", i), csr_mem[12'h343], tv[i].tval);
      chk($sformatf("trap%0d_mstatus", i), csr_mem[12'h300], tv[i].exp_mst);
      chk($sformatf("trap%0d_mst_writes", i), 32'(wr_cnt[12'h300] - s_mst), 32'd1);
      @(negedge clk_i);
      chk($sformatf("trap%0d_idle", i), {31'b0, busy_o}, 32'd0);
      chk($sformatf("trap%0d_priv", i), {30'b0, priv_mode_o}, 32'd3);
      chk($sformatf("trap%0d_pc_hold", i), redirect_pc_o, tv[i].exp_tgt);
      step();
    end

    for (int i = 0; i < 5; i++) begin
      pipe_csr_req_i = 1'b1; pipe_csr_addr_i = pv[i].addr;
      pipe_csr_wdata_i = pv[i].wdata; pipe_csr_we_i = pv[i].we;
      @(negedge clk_i);
      chk($sformatf("pipe%0d_gnt", i), {31'b0, pipe_csr_gnt_o}, 32'd1);
      chk($sformatf("pipe%0d_we", i), {31'b0, csr_write_en_o}, {31'b0, pv[i].we});
      chk($sformatf("pipe%0d_re", i), {31'b0, csr_read_en_o}, 32'd1);
      chk($sformatf("pipe%0d_addr", i), {20'b0, csr_addr_o}, {20'b0, pv[i].addr});
      chk($sformatf("pipe%0d_rdata", i), pipe_csr_rdata_o, pv[i].exp_rdata);
      step();
      pipe_csr_req_i = 1'b0; pipe_csr_we_i = 1'b0;
      @(negedge clk_i);
      chk($sformatf("pipe%0d_idle_rdata", i), pipe_csr_rdata_o, 32'd0);
      step();
    end

    do_mret("mret_a", 32'h0000_1880, 32'h0000_0084, 32'h0000_0088, 32'h0000_0084, 2'b11);
    do_mret("mret_b", 32'h0000_0088, 32'h0000_1003, 32'h0000_0088, 32'h0000_1000, 2'b00);

    // Trap taken from U-mode: MPP must capture 00.
    pipe_wr(12'h305, 32'h0000_0100);
    pipe_wr(12'h300, 32'h0000_0088);
    trap_req_i = 1'b1; trap_cause_i = 32'd3; trap_pc_i = 32'h0000_0300; trap_tval_i = 32'd0;
    step();
    trap_req_i = 1'b0;
    wait_redirect(k_seen, pc_seen, busy_all);
    chk("utrap_mstatus", csr_mem[12'h300], 32'h0000_0080);
    chk("utrap_redirect_pc", pc_seen, 32'h0000_0100);
    @(negedge clk_i);
    chk("utrap_priv", {30'b0, priv_mode_o}, 32'd3);
    step();

    // Trap, mret and pipe request together; a trap pulse while busy is dropped.
    pipe_wr(12'h300, 32'h0000_0008);
    snap();
    trap_req_i = 1'b1; mret_req_i = 1'b1; trap_cause_i = 32'd2;
    trap_pc_i = 32'h0000_0080; trap_tval_i = 32'h0000_DEAD;
    pipe_csr_req_i = 1'b1; pipe_csr_addr_i = 12'h305; pipe_csr_we_i = 1'b0;
    @(negedge clk_i);
    chk("coll_gnt_accept", {31'b0, pipe_csr_gnt_o}, 32'd0);
    step();
    trap_req_i = 1'b0; mret_req_i = 1'b0;
    k_seen = 0; gnt_k = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_i);
      if (redirect_valid_o && k_seen == 0) k_seen = k;
      if (pipe_csr_gnt_o && gnt_k == 0) gnt_k = k;
      trap_req_i = (k == 2);
      step();
      if (gnt_k != 0) break;
    end
    trap_req_i = 1'b0; pipe_csr_req_i = 1'b0;
    repeat (3) step();
    chk("coll_strobe_cycle", 32'(k_seen), 32'd7);
    chk("coll_first_gnt", 32'(gnt_k), 32'd8);
    chk("coll_mepc_writes", 32'(wr_cnt[12'h341] - s_mepc), 32'd1);
    chk("coll_mst_writes", 32'(wr_cnt[12'h300] - s_mst), 32'd1);
    chk("coll_redirects", 32'(redir_cnt - s_redir), 32'd1);
    chk("coll_mstatus", csr_mem[12'h300], 32'h0000_1880);

    do_mret("mret_c", 32'h0000_0000, 32'h0000_0040, 32'h0000_0080, 32'h0000_0040, 2'b00);

    // Reset during the mcause write cycle.
    snap();
    trap_req_i = 1'b1; trap_cause_i = 32'd5; trap_pc_i = 32'h0000_0400; trap_tval_i = 32'd9;
    step();
    trap_req_i = 1'b0;
    repeat (2) step();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rstmid_write_en", {31'b0, csr_write_en_o}, 32'd0);
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rstmid_busy", {31'b0, busy_o}, 32'd0);
    chk("rstmid_priv", {30'b0, priv_mode_o}, 32'd3);
    chk("rstmid_redirect_pc", redirect_pc_o, 32'd0);
    repeat (10) step();
    chk("rstmid_mepc_writes", 32'(wr_cnt[12'h341] - s_mepc), 32'd1);
    chk("rstmid_late_writes", 32'((wr_cnt[12'h342] - s_mcause) + (wr_cnt[12'h343] - s_mtval)
                                  + (wr_cnt[12'h300] - s_mst)), 32'd0);
    chk("rstmid_redirects", 32'(redir_cnt - s_redir), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rv32im_trap_seq.md
Name: rv32im_trap_seq

Overview:
Trap/return sequencer and access arbiter for the rv32im CSR register file. It owns the single CSR port (address, write data, read/write enables). It performs the multi-cycle CSR sequences for trap entry (mepc, mcause, mtval, mstatus, mtvec) and for mret. It also grants pipeline Zicsr accesses when idle. It sits between the execute stage and the CSR regfile, and drives PC redirect to fetch.

Parameters:
XLEN, 32, data width
CSR_AW, 12, CSR address width
RESET_PRIV, 2'b11, privilege mode after reset

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
trap_req_i  in  1  trap request; sampled only when busy_o=0
trap_cause_i  in  XLEN  mcause value; bit31 = interrupt
trap_pc_i  in  XLEN  faulting/interrupted PC
trap_tval_i  in  XLEN  mtval value
mret_req_i  in  1  mret request; sampled only when busy_o=0
pipe_csr_req_i  in  1  pipeline CSR access request
pipe_csr_addr_i  in  CSR_AW  pipeline CSR address
pipe_csr_wdata_i  in  XLEN  pipeline write data
pipe_csr_we_i  in  1  pipeline write enable
pipe_csr_gnt_o  out  1  pipeline access granted this cycle
pipe_csr_rdata_o  out  XLEN  read data for granted access
csr_addr_o  out  CSR_AW  to regfile
csr_wdata_o  out  XLEN  to regfile
csr_write_en_o  out  1  to regfile; write at next rising edge
csr_read_en_o  out  1  to regfile
csr_rdata_i  in  XLEN  regfile read data; combinational from csr_addr_o
priv_mode_o  out  2  current privilege
redirect_valid_o  out  1  one-cycle PC redirect strobe
redirect_pc_o  out  XLEN  redirect target
busy_o  out  1  sequence in progress (state != IDLE)

Behaviour:
- Reset (rst_i=1 at rising edge), reset values: state IDLE; redirect_valid_o=0; redirect_pc_o=0; busy_o=0; csr_write_en_o=0; csr_read_en_o=0; pipe_csr_gnt_o=0; priv_mode_o=RESET_PRIV; internal latches=0. Reset mid-sequence aborts immediately: no further CSR writes and no redirect.
- CSR addresses: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343.
- mstatus fields: MIE bit3, MPIE bit7, MPP[12:11].
- Priority in IDLE: trap > mret > pipeline.
  - Trap and mret in the same cycle: the trap is taken and the mret is dropped.
  - Requests while busy_o=1 are ignored; they are not queued.
- On accepting trap_req_i at edge N, latch cause, pc and tval. States, one cycle each:
  - T_RMST (N+1): read mstatus and latch it.
  - T_MEPC (N+2): write mepc = {pc[31:2],2'b00}.
  - T_MCAUSE (N+3): write mcause.
  - T_MTVAL (N+4): write mtval.
  - T_WMST (N+5): write mstatus with MPIE<=MIE, MIE<=0, MPP<=priv_mode_o, all other bits unchanged.
  - T_RVEC (N+6): read mtvec and compute the target.
  - REDIRECT (N+7): redirect_valid_o=1; priv_mode_o<=2'b11 at the end of this cycle; then IDLE.
- Trap target, with base={mtvec[31:2],2'b00}:
  - mtvec[1:0]==01 and cause[31]==1: base + (cause[30:0]<<2), computed modulo 2^32.
  - Otherwise: base.
- mret, accepted at edge N. States, one cycle each:
  - M_RMST (N+1): read and latch mstatus.
  - M_WMST (N+2): write mstatus with MIE<=MPIE, MPIE<=1, MPP<=2'b00; latch old MPP.
  - M_RMEPC (N+3): read mepc; target = {mepc[31:2],2'b00}.
  - REDIRECT (N+4): redirect_valid_o=1; priv_mode_o<=old MPP; then IDLE.
- Enables during sequences: csr_write_en_o=1 only in write states; csr_read_en_o=1 only in read states. Both are 0 in IDLE without a grant and in REDIRECT.
- Pipeline grant (combinational): pipe_csr_gnt_o = pipe_csr_req_i & IDLE & ~trap_req_i & ~mret_req_i.
  - When granted, csr_addr_o, csr_wdata_o and csr_write_en_o follow the pipe inputs, and csr_read_en_o=1.
  - pipe_csr_rdata_o = csr_rdata_i in the grant cycle (read-before-write value); it is 0 otherwise.
  - The requester holds its request until granted.
- redirect_pc_o holds its last value between strobes.
- busy_o=1 from N+1 through REDIRECT inclusive.

Test Plan:
- Direct-mode trap: mtvec=0x00000100, mstatus=0x00000008, priv=11, trap cause=2, pc=0x80, tval=0xDEAD. Expect mepc=0x80, mcause=2, mtval=0xDEAD, mstatus=0x00001880, redirect_pc_o=0x100 with the strobe at N+7, priv=11.
- Vectored interrupt: mtvec=0x00000201, cause=0x80000007. Expect redirect_pc_o=0x21C. Repeat with cause=2 and expect 0x200.
- mret after the first scenario, with mepc=0x84. Expect mstatus=0x00000088, redirect_pc_o=0x84 at N+4, priv_mode_o=11 (old MPP).
- Pipeline access: write 0x300 <- 0xF0000000, then read it back. Expect gnt the same cycle, csr_write_en_o=1, then rdata=0xF0000000. During a trap sequence, a held pipe request sees gnt=0 until the cycle after REDIRECT.
- Trap, mret and pipe request in the same cycle: trap sequence runs, no mret effects, gnt=0. A trap_req_i pulse while busy is ignored, giving exactly one mepc write.
- rst_i asserted at N+3 of a trap: next cycle state IDLE, busy_o=0, no mcause/mtval/mstatus writes, no redirect_valid_o, priv_mode_o=RESET_PRIV.
